load_store_unit: RTL and testbench

Initiator side of the word-wide data memory port in the KGP-RISC datapath. Accepts load/store requests from the execute stage and drives the memory's address, write-data and write-enable lines. Handles byte, halfword and word accesses, and returns sign- or zero-extended load data. Because the memory always writes a full 32-bit word, sub-word stores are done as read-modify-write.

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-wide data memory port. Accepts one load/store
//   request at a time from the execute stage and drives the memory address,
//   write data and write enable. Supports byte, halfword and word accesses.
//   Load data is returned sign- or zero-extended. The memory only writes
//   whole words, so sub-word stores are done as read-modify-write.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned halfword/word requests complete immediately with
//                 rsp_err = 1 and no memory access.
//     undefined : misalignment is ignored (halfword uses addr[1], word ignores
//                 addr[1:0]) and rsp_err is always 0.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     req_valid/ready  request handshake (accept on valid && ready)
//     req_we           1 = store, 0 = load
//     req_size         00 byte, 01 halfword, 10/11 word
//     req_signed       load extension: 1 = sign, 0 = zero
//     req_addr         byte address
//     req_wdata        right-aligned store data
//     rsp_valid        one-cycle completion pulse
//     rsp_rdata        extended load data (0 for stores and errors)
//     rsp_err          misaligned access flag
//     mem_addr         word-aligned memory address
//     mem_wdata        memory write data
//     mem_wren         memory write enable (4'b0000 or 4'b1111)
//     mem_rdata        combinational memory read data of mem_addr
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_misaligned;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    if (req_size[1])
      req_misaligned = (req_addr[1:0] != 2'b00);
    else if (req_size[0])
      req_misaligned = req_addr[0];
  end
`else
  assign req_misaligned = 1'b0;
`endif

  // Lane extraction and sign/zero extension of the addressed load data.
  always_comb begin
    byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext  = mem_rdata;
    if (!size_q[1]) begin
      if (size_q[0])
        load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      else
        load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
    end
  end

  // Old memory word with the addressed store lane replaced.
  always_comb begin
    merged = mem_rdata;
    if (size_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // wdata_q doubles as the mem_wdata register: it holds the right-aligned
  // store data after accept and is overwritten with the merged word before
  // WRITE, so the memory only ever sees registered write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_misaligned;
            state    <= req_misaligned ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_ext;
            state   <= S_RESP;
          end else if (size_q[1]) begin
            state <= S_RESP;
          end else begin
            wdata_q <= merged;
            state   <= S_WRITE;
          end
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = {addr_q[31:ADDR_BITS], addr_q[ADDR_BITS-1:2], 2'b00};

  // Decoded from state and latched request only; an asynchronous reset
  // forces IDLE and therefore drops the enable at once.
  assign mem_wren = ((state == S_WRITE) || (state == S_ACCESS && we_q && size_q[1]))
                    ? '1 : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_BITS(18)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata)
  );

  // Environment memory: 1024 words, combinational read, whole-word write.
  logic [31:0] mem [0:1023];
  logic        mem_clr = 1'b1;
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (mem_wren == 4'hF) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state and scoreboard.
  logic [31:0] ref_mem [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned wrens;
    int unsigned acc;
    int unsigned idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int unsigned wren_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: computes the response from the access rules and
  // updates the shadow memory.
  function automatic exp_t model(input logic we, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t        e;
    logic        mis;
    int unsigned idx;
    int unsigned sh;
    int unsigned hsh;
    logic [31:0] w;
    logic [31:0] v;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    idx = int'(a[11:2]);
    sh  = 8 * int'(a[1:0]);
    hsh = 16 * int'(a[1]);
    w   = ref_mem[idx];
    e.err = mis; e.rdata = '0; e.idx = idx; e.wrens = 0; e.acc = 0; e.lat = 1;
    if (!mis) begin
      if (!we) begin
        e.lat = 2;
        if (sz[1]) v = w;
        else if (sz[0]) begin
          v = (w >> hsh) & 32'h0000FFFF;
          if (sg && v[15]) v = v | 32'hFFFF0000;
        end else begin
          v = (w >> sh) & 32'h000000FF;
          if (sg && v[7]) v = v | 32'hFFFFFF00;
        end
        e.rdata = v;
      end else begin
        e.wrens = 1;
        if (sz[1]) begin
          e.lat = 2;
          ref_mem[idx] = wd;
        end else if (sz[0]) begin
          e.lat = 3;
          ref_mem[idx] = (w & ~(32'h0000FFFF << hsh)) | ((wd & 32'h0000FFFF) << hsh);
        end else begin
          e.lat = 3;
          ref_mem[idx] = (w & ~(32'h000000FF << sh)) | ((wd & 32'h000000FF) << sh);
        end
      end
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wren_cnt = 0;
      end else begin
        if (mem_wren != 4'h0) begin
          chk("wren_shape", {28'h0, mem_wren}, 32'hF);
          if (mem_wren == 4'hF) wren_cnt++;
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            chk("latency", cyc - e.acc, e.lat - 1);
            chk("wren_cycles", wren_cnt, e.wrens);
            chk("mem_word", mem[e.idx], ref_mem[e.idx]);
          end
          wren_cnt = 0;
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit track, output int unsigned acc);
    int   n;
    exp_t e;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = 0;
    if (!req_ready) begin
      chk("ready_timeout", 32'h0, 32'h1);
    end else begin
      if (track) e = model(we, sz, sg, a, wd);
      @(posedge clk);
      #1;
      acc = cyc;
      if (track) begin
        e.acc = acc;
        q.push_back(e);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      end
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int unsigned acc;
    int unsigned accs [4];
    int unsigned n;
    logic [31:0] r;
    logic [31:0] r2;

    fork
      monitor();
    join_none

    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_wren", {28'h0, mem_wren}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    #2;
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 1'b1, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b1, acc);

    // Byte store into a known word; check the merged word seen in WRITE
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h11223344, 1'b1, acc);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0202, 32'h000000AB, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    chk("write_wdata", mem_wdata, 32'h11AB3344);
    chk("write_wren", {28'h0, mem_wren}, 32'hF);

    // Signed / unsigned sub-word loads
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h80F0017F, 1'b1, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0300, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0302, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0302, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0302, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0, 1'b1, acc);

    // Misaligned halfword store and word load
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000CAFE, 1'b1, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 1'b1, acc);

    // Reset in the middle of a read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h00000055, 1'b0, acc);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_write_wren", {28'h0, mem_wren}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_wren", {28'h0, mem_wren}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_word_kept", mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // Back-to-back word loads with req_valid held high
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 1'b1, acc);
      accs[i] = acc;
    end
    for (int i = 1; i < 4; i++) chk("b2b_spacing", accs[i] - accs[i-1], 32'd3);
    drop_valid();

    // Randomized traffic over a small window of words
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      r2 = $urandom();
      issue(r2[0], r2[2:1], r2[3], {r[31:12], 6'h04, r[5:0]}, $urandom(), 1'b1, acc);
      if (r2[7:5] == 3'b000) begin
        drop_valid();
        repeat (int'(r2[9:8])) @(negedge clk);
      end
    end
    drop_valid();

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'h0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
